// File: rtl/rng_share_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rng_share_arbiter_pkg                                        |
// | Description : LCG constants and arbiter FSM state encoding shared by the   |
// |               random-source arbiter and its LCG core.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rng_share_arbiter_pkg;

  // Classic ANSI-C style LCG coefficients.
  localparam logic [31:0] c_LCG_MULT = 32'd1103515245;
  localparam logic [31:0] c_LCG_INC  = 32'd12345;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_DELIVER = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rng_share_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rng_share_arbiter_if                                         |
// | Description : Requester-side bundle of the shared random source: request  |
// |               levels, reseed control and the granted random word.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rng_share_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]    req;
  logic                  seed_load;
  logic [DATA_WIDTH-1:0] seed_val;
  logic                  rnd_valid;
  logic [NUM_REQ-1:0]    rnd_grant;
  logic [DATA_WIDTH-1:0] rnd_data;
  logic                  busy;

  // Clients drive requests and reseed commands.
  modport master (
    output req, seed_load, seed_val,
    input  rnd_valid, rnd_grant, rnd_data, busy
  );

  // The arbiter consumes requests and produces the granted word.
  modport slave (
    input  req, seed_load, seed_val,
    output rnd_valid, rnd_grant, rnd_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/rng_share_arbiter_lcg_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcg_core                                                     |
// | Description : Linear congruential generator state register.               |
// |               state <= state*MULT + INC (mod 2^DATA_WIDTH) on i_step,     |
// |               state <= i_load_val on i_load (load wins over step).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcg_core
  import rng_share_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(123456)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_step,
  input  wire logic                  i_load,
  input  wire logic [DATA_WIDTH-1:0] i_load_val,
  output logic      [DATA_WIDTH-1:0] o_state
);

  localparam logic [DATA_WIDTH-1:0] c_MULT = DATA_WIDTH'(c_LCG_MULT);
  localparam logic [DATA_WIDTH-1:0] c_INC  = DATA_WIDTH'(c_LCG_INC);

  logic [DATA_WIDTH-1:0] r_state;
  logic [DATA_WIDTH-1:0] w_next;

  // Next LCG value; truncation to DATA_WIDTH gives the modulo for free.
  always_comb begin
    w_next = r_state * c_MULT + c_INC;
  end

  // State register: reseed takes priority over a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_step) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/rng_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rng_share_arbiter                                            |
// | Description : Round-robin sharing of one LCG among NUM_REQ requesters.    |
// |               One random word per grant, delivered as a one-cycle pulse   |
// |               to the winner only. Run-time reseed aborts any grant.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rng_share_arbiter
  import rng_share_arbiter_pkg::*;
#(
  parameter int                    NUM_REQ    = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(123456)
) (
  input wire logic          clk,
  input wire logic          rst,
  rng_share_arbiter_if.slave bus
);

  localparam int               PTR_W  = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   c_NREQ = (PTR_W + 1)'(NUM_REQ);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_winner;
  logic [PTR_W-1:0]      w_ptr_next;
  logic [PTR_W-1:0]      w_scan_ptr;
  logic [PTR_W-1:0]      w_win_idx;
  logic [PTR_W:0]        w_scan_sum;
  logic                  w_scan_hit;
  logic                  w_take_winner;
  logic                  w_deliver;
  logic                  w_ptr_adv;
  logic                  w_lcg_load;
  logic [DATA_WIDTH-1:0] w_lcg_state;
  logic [NUM_REQ-1:0]    w_onehot;

  logic                  r_rnd_valid;
  logic [NUM_REQ-1:0]    r_rnd_grant;
  logic [DATA_WIDTH-1:0] r_rnd_data;
  logic                  r_busy;

  // The LCG steps on entry to GRANT so the post-step word is already held
  // in its register during GRANT and can be captured straight into rnd_data.
  lcg_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEED       (SEED)
  ) u_lcg_core (
    .clk        (clk),
    .rst        (rst),
    .i_step     (w_take_winner),
    .i_load     (w_lcg_load),
    .i_load_val (bus.seed_val),
    .o_state    (w_lcg_state)
  );

  // Pointer after the current winner, wrapping at NUM_REQ-1.
  always_comb begin
    w_ptr_next = (r_winner == c_LAST) ? '0 : r_winner + 1'b1;
    // Leaving DELIVER the pointer is advancing this very edge, so arbitrate
    // from its new value to keep the just-served requester at the back.
    w_scan_ptr = (r_state == ST_DELIVER) ? w_ptr_next : r_rr_ptr;
  end

  // Round-robin search: first asserted request starting at w_scan_ptr.
  always_comb begin
    w_win_idx  = r_winner;
    w_scan_hit = 1'b0;
    w_scan_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_sum = {1'b0, w_scan_ptr} + (PTR_W + 1)'(k);
      if (w_scan_sum >= c_NREQ) begin
        w_scan_sum = w_scan_sum - c_NREQ;
      end
      if (!w_scan_hit && bus.req[w_scan_sum[PTR_W-1:0]]) begin
        w_scan_hit = 1'b1;
        w_win_idx  = w_scan_sum[PTR_W-1:0];
      end
    end
  end

  // FSM next-state and control strobes; reseed overrides every state.
  always_comb begin
    w_state_nxt   = r_state;
    w_take_winner = 1'b0;
    w_deliver     = 1'b0;
    w_ptr_adv     = 1'b0;
    w_lcg_load    = 1'b0;
    if (bus.seed_load) begin
      w_state_nxt = ST_IDLE;
      w_lcg_load  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) begin
            w_state_nxt   = ST_GRANT;
            w_take_winner = 1'b1;
          end
        end
        ST_GRANT: begin
          w_state_nxt = ST_DELIVER;
          w_deliver   = 1'b1;
        end
        ST_DELIVER: begin
          w_ptr_adv = 1'b1;
          if (|bus.req) begin
            w_state_nxt   = ST_GRANT;
            w_take_winner = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // One-hot owner of the word being delivered.
  always_comb begin
    w_onehot = {{(NUM_REQ - 1){1'b0}}, 1'b1} << r_winner;
  end

  // Pointer, winner and registered outputs; outputs are zero outside DELIVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_winner    <= '0;
      r_rnd_valid <= 1'b0;
      r_rnd_grant <= '0;
      r_rnd_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_ptr_adv) begin
        r_rr_ptr <= w_ptr_next;
      end
      if (w_take_winner) begin
        r_winner <= w_win_idx;
      end
      r_rnd_valid <= w_deliver;
      r_rnd_grant <= w_deliver ? w_onehot : '0;
      r_rnd_data  <= w_deliver ? w_lcg_state : '0;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.rnd_valid = r_rnd_valid;
  assign bus.rnd_grant = r_rnd_grant;
  assign bus.rnd_data  = r_rnd_data;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rng_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rng_share_arbiter                                         |
// | Description : Directed self-checking bench for rng_share_arbiter with an  |
// |               expected-word scoreboard.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rng_share_arbiter;

  typedef struct packed {
    logic [3:0]  grant;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] m_lcg = 32'd123456;
  exp_t sb[$];

  rng_share_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

  rng_share_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .SEED       (32'd123456)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'd1103515245 + 32'd12345;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Queue the next word the requester with one-hot g should receive.
  task automatic expect_word(input logic [3:0] g);
    m_lcg = lcg(m_lcg);
    sb.push_back('{grant: g, data: m_lcg});
  endtask

  // Advance one clock, then check outputs against the scoreboard.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.rnd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", bus.rnd_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_grant", bus.rnd_grant, e.grant);
        chk("sb_data", bus.rnd_data, e.data);
      end
    end else begin
      chk("idle_grant", bus.rnd_grant, 0);
      chk("idle_data", bus.rnd_data, 0);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.req       = 4'b0000;
    bus.seed_load = 1'b0;
    bus.seed_val  = 32'd0;

    // Reset state
    cycles(2);
    chk("rst_valid", bus.rnd_valid, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;

    // 1: single requester held, first word and latency
    bus.req = 4'b0001;
    expect_word(4'b0001);
    expect_word(4'b0001);
    cycle();
    chk("lat_busy", bus.busy, 1);
    chk("lat_valid0", bus.rnd_valid, 0);
    cycle();
    chk("lat_valid1", bus.rnd_valid, 1);
    chk("first_word", bus.rnd_data, 32'd3510437241);
    cycles(2);
    bus.req = 4'b0000;
    cycles(2);
    chk("s1_sb_empty", sb.size(), 0);
    chk("s1_busy", bus.busy, 0);

    // 2: all requesting, rotation every second cycle from rr_ptr=0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_lcg = 32'd123456;
    bus.req = 4'b1111;
    expect_word(4'b0001);
    expect_word(4'b0010);
    expect_word(4'b0100);
    expect_word(4'b1000);
    expect_word(4'b0001);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("thr_valid", bus.rnd_valid, (i % 2 == 1) ? 1 : 0);
    end
    bus.req = 4'b0000;
    cycle();
    chk("s2_sb_empty", sb.size(), 0);

    // 3: move rr_ptr to 2, then req=0011 wraps to 0 then 1
    bus.req = 4'b0010;
    expect_word(4'b0010);
    cycles(2);
    bus.req = 4'b0000;
    cycle();
    bus.req = 4'b0011;
    expect_word(4'b0001);
    expect_word(4'b0010);
    cycles(2);
    chk("wrap_grant", bus.rnd_grant, 4'b0001);
    cycles(2);
    chk("wrap_next", bus.rnd_grant, 4'b0010);
    bus.req = 4'b0000;
    cycle();
    chk("s3_sb_empty", sb.size(), 0);

    // 4: reseed during GRANT aborts the grant
    bus.req = 4'b0001;
    cycle();
    chk("s4_in_grant", bus.busy, 1);
    bus.seed_load = 1'b1;
    bus.seed_val  = 32'd123456;
    cycle();
    chk("seed_no_valid", bus.rnd_valid, 0);
    chk("seed_busy", bus.busy, 0);
    bus.seed_load = 1'b0;
    m_lcg = 32'd123456;
    expect_word(4'b0001);
    cycle();
    chk("seed_no_valid2", bus.rnd_valid, 0);
    cycle();
    chk("seed_data", bus.rnd_data, 32'd3510437241);
    bus.req = 4'b0000;
    cycle();
    chk("s4_sb_empty", sb.size(), 0);

    // 5: reset during DELIVER
    bus.req = 4'b0010;
    expect_word(4'b0010);
    cycles(2);
    chk("s5_deliver", bus.rnd_valid, 1);
    rst = 1'b1;
    bus.req = 4'b0000;
    cycle();
    chk("rst_mid_valid", bus.rnd_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
    rst = 1'b0;
    m_lcg = 32'd123456;
    bus.req = 4'b1111;
    expect_word(4'b0001);
    cycles(2);
    chk("rst_lcg", bus.rnd_data, 32'd3510437241);
    bus.req = 4'b0000;
    cycle();

    // 6: one-cycle request pulse is still served exactly once
    bus.req = 4'b0100;
    expect_word(4'b0100);
    cycle();
    bus.req = 4'b0000;
    cycle();
    chk("pulse_grant", bus.rnd_grant, 4'b0100);
    cycles(4);
    chk("s6_sb_empty", sb.size(), 0);
    chk("s6_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
